// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the native mem bus, with per-master completion counters.
// Define ARB_TIMEOUT_EN to force completion of a grant that waits TIMEOUT_CYCLES without s_ready.
module mem_bus_arbiter #(
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             m0_valid,
    output logic             m0_ready,
    input  logic [31:0]      m0_addr,
    input  logic [31:0]      m0_wdata,
    input  logic [3:0]       m0_wstrb,
    output logic [31:0]      m0_rdata,

    input  logic             m1_valid,
    output logic             m1_ready,
    input  logic [31:0]      m1_addr,
    input  logic [31:0]      m1_wdata,
    input  logic [3:0]       m1_wstrb,
    output logic [31:0]      m1_rdata,

    output logic             s_valid,
    input  logic             s_ready,
    output logic [31:0]      s_addr,
    output logic [31:0]      s_wdata,
    output logic [3:0]       s_wstrb,
    input  logic [31:0]      s_rdata,

    output logic [1:0]       grant,
    output logic [CNT_W-1:0] m0_count,
    output logic [CNT_W-1:0] m1_count,
    output logic             timeout_err
);

    localparam logic [31:0] TMO_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

    state_e           state_q, state_d;
    logic             last_grant_q;
    logic [CNT_W-1:0] m0_count_q, m1_count_q;
    logic             tmo_fire;
    logic             g0, g1;

    // State register; last_grant tracks the owner of the most recent grant entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_d == StGrant0) begin
                last_grant_q <= 1'b0;
            end else if (state_d == StGrant1) begin
                last_grant_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (m0_valid && m1_valid) begin
                    state_d = last_grant_q ? StGrant0 : StGrant1;
                end else if (m0_valid) begin
                    state_d = StGrant0;
                end else if (m1_valid) begin
                    state_d = StGrant1;
                end
            end
            StGrant0, StGrant1: begin
                if (s_ready || tmo_fire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        g0          = (state_q == StGrant0);
        g1          = (state_q == StGrant1);
        grant       = {g1, g0};
        s_valid     = (g0 | g1) & ~tmo_fire;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        if (g0) begin
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
            s_wstrb = m0_wstrb;
        end else if (g1) begin
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_wstrb = m1_wstrb;
        end
        m0_ready    = g0 & (s_ready | tmo_fire);
        m1_ready    = g1 & (s_ready | tmo_fire);
        m0_rdata    = g0 ? (tmo_fire ? TMO_RDATA : s_rdata) : 32'h0;
        m1_rdata    = g1 ? (tmo_fire ? TMO_RDATA : s_rdata) : 32'h0;
        timeout_err = tmo_fire;
        m0_count    = m0_count_q;
        m1_count    = m1_count_q;
    end

    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0_count_q <= '0;
            m1_count_q <= '0;
        end else begin
            if (m0_ready) m0_count_q <= m0_count_q + 1'b1;
            if (m1_ready) m1_count_q <= m1_count_q + 1'b1;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 2);

    logic [TMO_W-1:0] tmo_q;

    // Held at zero while idle, so it starts from zero on every grant entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else if (state_q == StIdle || s_ready || tmo_fire) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    // A real s_ready in the expiry cycle takes precedence over the forced completion.
    assign tmo_fire = (state_q != StIdle) && !s_ready && (tmo_q == TMO_W'(TIMEOUT_CYCLES));
`else
    assign tmo_fire = 1'b0;
`endif

endmodule
